// File: rtl/ysyx_041514_ram_rd_arbiter.sv
// ysyx_041514_ram_rd_arbiter: two-requester (icache/dcache) read arbiter onto
// one shared memory read port, burst-locked until the last beat or an abort.
// Ports: clk, rst (sync, active-high); i_*/d_* request + beat strobe/data;
// ram_* shared request + beat strobe/data; grant_o {d,i} one-hot, busy_o.
// Macro YSYX_041514_ARB_RR_EN: round-robin on simultaneous requests
// (dcache favoured after reset); undefined: dcache has fixed priority.
module ysyx_041514_ram_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_raddr_i,
  input  logic              i_raddr_valid_i,
  input  logic [7:0]        i_rmask_i,
  input  logic [3:0]        i_rsize_i,
  input  logic [7:0]        i_rlen_i,
  output logic              i_rdata_ready_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic [ADDR_W-1:0] d_raddr_i,
  input  logic              d_raddr_valid_i,
  input  logic [7:0]        d_rmask_i,
  input  logic [3:0]        d_rsize_i,
  input  logic [7:0]        d_rlen_i,
  output logic              d_rdata_ready_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  output logic              ram_raddr_valid_o,
  output logic [7:0]        ram_rmask_o,
  output logic [3:0]        ram_rsize_o,
  output logic [7:0]        ram_rlen_o,
  input  logic              ram_rdata_ready_i,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [7:0] rlen_q;
  logic       sel_i;
  logic       sel_d;
  logic       hs;
  logic       pick_d;

`ifdef YSYX_041514_ARB_RR_EN
  // last_d: dcache won the previous arbitration; 0 after reset
  logic last_d;
  assign pick_d = d_raddr_valid_i & (~i_raddr_valid_i | ~last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE &&
                 (d_raddr_valid_i || i_raddr_valid_i)) begin
      last_d <= pick_d;
    end
  end
`else
  assign pick_d = d_raddr_valid_i;
`endif

  assign sel_i   = (state == GNT_I);
  assign sel_d   = (state == GNT_D);
  assign grant_o = {sel_d, sel_i};
  assign busy_o  = sel_i | sel_d;

  // granted valid is forwarded live, so a dropped valid
  // suppresses the beat strobe in the same cycle
  always_comb begin
    ram_raddr_o       = '0;
    ram_raddr_valid_o = 1'b0;
    ram_rmask_o       = '0;
    ram_rsize_o       = '0;
    ram_rlen_o        = '0;
    unique case (1'b1)
      sel_i: begin
        ram_raddr_o       = i_raddr_i;
        ram_raddr_valid_o = i_raddr_valid_i;
        ram_rmask_o       = i_rmask_i;
        ram_rsize_o       = i_rsize_i;
        ram_rlen_o        = i_rlen_i;
      end
      sel_d: begin
        ram_raddr_o       = d_raddr_i;
        ram_raddr_valid_o = d_raddr_valid_i;
        ram_rmask_o       = d_rmask_i;
        ram_rsize_o       = d_rsize_i;
        ram_rlen_o        = d_rlen_i;
      end
      default: ;
    endcase
  end

  assign hs              = ram_raddr_valid_o & ram_rdata_ready_i;
  assign i_rdata_ready_o = sel_i & hs;
  assign d_rdata_ready_o = sel_d & hs;
  assign i_rdata_o       = ram_rdata_i;
  assign d_rdata_o       = ram_rdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      rlen_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_d) begin
            state  <= GNT_D;
            rlen_q <= d_rlen_i;
          end else if (i_raddr_valid_i) begin
            state  <= GNT_I;
            rlen_q <= i_rlen_i;
          end
        end
        GNT_I, GNT_D: begin
          if (!ram_raddr_valid_o) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (hs) begin
            // cnt == rlen_q before wrap, so rlen 255 ends at 256 beats
            if (cnt == rlen_q) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041514_ram_rd_arbiter.sv
// tb_ysyx_041514_ram_rd_arbiter: directed bench for the ram read arbiter.
// Linear stimulus, immediate assertions, one summary line.
module tb_ysyx_041514_ram_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_raddr_i, d_raddr_i, ram_raddr_o;
  logic        i_raddr_valid_i, d_raddr_valid_i, ram_raddr_valid_o;
  logic [7:0]  i_rmask_i, d_rmask_i, ram_rmask_o;
  logic [3:0]  i_rsize_i, d_rsize_i, ram_rsize_o;
  logic [7:0]  i_rlen_i, d_rlen_i, ram_rlen_o;
  logic        i_rdata_ready_o, d_rdata_ready_o, ram_rdata_ready_i;
  logic [63:0] i_rdata_o, d_rdata_o, ram_rdata_i;
  logic [1:0]  grant_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp3 [4];

  always #5 clk = ~clk;

  ysyx_041514_ram_rd_arbiter #(.ADDR_W(32), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .i_raddr_i(i_raddr_i), .i_raddr_valid_i(i_raddr_valid_i),
    .i_rmask_i(i_rmask_i), .i_rsize_i(i_rsize_i), .i_rlen_i(i_rlen_i),
    .i_rdata_ready_o(i_rdata_ready_o), .i_rdata_o(i_rdata_o),
    .d_raddr_i(d_raddr_i), .d_raddr_valid_i(d_raddr_valid_i),
    .d_rmask_i(d_rmask_i), .d_rsize_i(d_rsize_i), .d_rlen_i(d_rlen_i),
    .d_rdata_ready_o(d_rdata_ready_o), .d_rdata_o(d_rdata_o),
    .ram_raddr_o(ram_raddr_o), .ram_raddr_valid_o(ram_raddr_valid_o),
    .ram_rmask_o(ram_rmask_o), .ram_rsize_o(ram_rsize_o),
    .ram_rlen_o(ram_rlen_o), .ram_rdata_ready_i(ram_rdata_ready_i),
    .ram_rdata_i(ram_rdata_i), .grant_o(grant_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Called in the first granted cycle; runs until busy drops.
  task automatic burst(input string tag, input logic [1:0] g,
                       input int exp_beats, input bit stall);
    int beats = 0;
    int cyc = 0;
    logic held = 1'b1;
    while (busy_o && cyc < 2000) begin
      if (grant_o !== g) held = 1'b0;
      if (g[0] ? d_rdata_ready_o : i_rdata_ready_o) held = 1'b0;
      beats += g[0] ? int'(i_rdata_ready_o) : int'(d_rdata_ready_o);
      cyc++;
      @(posedge clk);
      #1;
      ram_rdata_ready_i = stall ? (cyc % 3 == 2) : 1'b1;
      #1;
    end
    chk({tag, "_beats"}, 64'(beats), 64'(exp_beats));
    chk({tag, "_held"}, 64'(held), 64'd1);
    chk({tag, "_done"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
`ifdef YSYX_041514_ARB_RR_EN
    exp3 = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
    exp3 = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
    rst = 1'b1;
    i_raddr_i = '0; i_raddr_valid_i = 0; i_rmask_i = '0;
    i_rsize_i = '0; i_rlen_i = '0;
    d_raddr_i = '0; d_raddr_valid_i = 0; d_rmask_i = '0;
    d_rsize_i = '0; d_rlen_i = '0;
    ram_rdata_ready_i = 0; ram_rdata_i = '0;
    step; step;
    chk("rst_grant", 64'(grant_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_valid", 64'(ram_raddr_valid_o), 0);
    chk("rst_iready", 64'(i_rdata_ready_o), 0);
    chk("rst_dready", 64'(d_rdata_ready_o), 0);
    rst = 1'b0;

    // icache-only 8-beat burst
    step;
    i_raddr_i = 32'h8000_0040; i_rlen_i = 8'd7; i_rmask_i = 8'hff;
    i_rsize_i = 4'd3; i_raddr_valid_i = 1; ram_rdata_ready_i = 1;
    ram_rdata_i = 64'hdead_beef_0123_4567;
    #1;
    chk("t1_lat_grant", 64'(grant_o), 0);
    chk("t1_lat_valid", 64'(ram_raddr_valid_o), 0);
    chk("t1_bcast_i", i_rdata_o, 64'hdead_beef_0123_4567);
    chk("t1_bcast_d", d_rdata_o, 64'hdead_beef_0123_4567);
    step;
    chk("t1_grant", 64'(grant_o), 64'b01);
    chk("t1_busy", 64'(busy_o), 1);
    chk("t1_addr", 64'(ram_raddr_o), 64'h8000_0040);
    chk("t1_rlen", 64'(ram_rlen_o), 7);
    chk("t1_mask", 64'(ram_rmask_o), 64'hff);
    burst("t1", 2'b01, 8, 1'b0);
    i_raddr_valid_i = 0; ram_rdata_i = '0;

    // simultaneous requests: dcache first
    d_raddr_i = 32'h8000_1000; d_rlen_i = 8'd3; d_raddr_valid_i = 1;
    i_raddr_i = 32'h8000_2000; i_rlen_i = 8'd1; i_raddr_valid_i = 1;
    #1;
    step;
    chk("t2_grant_d", 64'(grant_o), 64'b10);
    chk("t2_addr_d", 64'(ram_raddr_o), 64'h8000_1000);
    chk("t2_iready", 64'(i_rdata_ready_o), 0);
    burst("t2d", 2'b10, 4, 1'b0);
    chk("t2_idle", 64'(grant_o), 0);
    d_raddr_valid_i = 0;
    step;
    chk("t2_grant_i", 64'(grant_o), 64'b01);
    chk("t2_addr_i", 64'(ram_raddr_o), 64'h8000_2000);
    burst("t2i", 2'b01, 2, 1'b0);
    i_raddr_valid_i = 0;

    // both valid continuously, single-beat bursts
    d_rlen_i = 8'd0; i_rlen_i = 8'd0;
    d_raddr_valid_i = 1; i_raddr_valid_i = 1;
    #1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk($sformatf("t3_grant%0d", k), 64'(grant_o), 64'(exp3[k]));
      chk($sformatf("t3_ready%0d", k),
          64'(exp3[k][0] ? i_rdata_ready_o : d_rdata_ready_o), 1);
      step;
      chk($sformatf("t3_idle%0d", k), 64'(grant_o), 0);
    end
    d_raddr_valid_i = 0; i_raddr_valid_i = 0;

    // dcache abort after 3 of 8 beats, icache pending
    d_raddr_i = 32'h8000_3000; d_rlen_i = 8'd7; i_rlen_i = 8'd0;
    d_raddr_valid_i = 1; i_raddr_valid_i = 1;
    #1;
    step;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("t4_beat%0d", j), 64'(d_rdata_ready_o), 1);
      chk($sformatf("t4_hold%0d", j), 64'(grant_o), 64'b10);
      step;
    end
    d_raddr_valid_i = 0;
    #1;
    chk("t4_drop_ready", 64'(d_rdata_ready_o), 0);
    chk("t4_drop_valid", 64'(ram_raddr_valid_o), 0);
    step;
    chk("t4_idle_grant", 64'(grant_o), 0);
    chk("t4_idle_busy", 64'(busy_o), 0);
    chk("t4_idle_dready", 64'(d_rdata_ready_o), 0);
    step;
    chk("t4_grant_i", 64'(grant_o), 64'b01);
    chk("t4_iready", 64'(i_rdata_ready_o), 1);
    i_raddr_valid_i = 0;
    step;
    chk("t4_end", 64'(grant_o), 0);

    // reset during beat 4, then fresh burst; rlen change ignored
    i_raddr_i = 32'h8000_4000; i_rlen_i = 8'd7; i_raddr_valid_i = 1;
    #1;
    step; step; step; step;
    chk("t5_beat4", 64'(i_rdata_ready_o), 1);
    rst = 1'b1;
    step;
    chk("t5_rst_grant", 64'(grant_o), 0);
    chk("t5_rst_busy", 64'(busy_o), 0);
    chk("t5_rst_valid", 64'(ram_raddr_valid_o), 0);
    chk("t5_rst_iready", 64'(i_rdata_ready_o), 0);
    rst = 1'b0;
    step;
    chk("t5_regrant", 64'(grant_o), 64'b01);
    i_rlen_i = 8'd2;
    #1;
    burst("t5", 2'b01, 8, 1'b0);
    i_raddr_valid_i = 0;

    // 256-beat burst with ready every third cycle
    d_raddr_i = 32'h8000_5000; d_rlen_i = 8'd255; d_raddr_valid_i = 1;
    ram_rdata_ready_i = 0;
    #1;
    step;
    chk("t6_grant", 64'(grant_o), 64'b10);
    burst("t6", 2'b10, 256, 1'b1);
    d_raddr_valid_i = 0; ram_rdata_ready_i = 1;
    step;
    chk("t6_end", 64'(grant_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_041514_ram_rd_arbiter.md
YSYX_041514_RAM_RD_ARBITER -- requirements
Module: ysyx_041514_ram_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 64: read data width of all data ports.
REQ-003 SHALL have port clk  input  1: clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have ports i_raddr_i  input  ADDR_W, i_raddr_valid_i  input  1, i_rmask_i  input  8, i_rsize_i  input  4, i_rlen_i  input  8: icache read request.
REQ-006 SHALL have ports i_rdata_ready_o  output  1, i_rdata_o  output  DATA_W: icache beat strobe and data.
REQ-007 SHALL have ports d_raddr_i, d_raddr_valid_i, d_rmask_i, d_rsize_i, d_rlen_i, d_rdata_ready_o, d_rdata_o: dcache request and response, with the same directions and widths as REQ-005/006.
REQ-008 SHALL have ports ram_raddr_o  output  ADDR_W, ram_raddr_valid_o  output  1, ram_rmask_o  output  8, ram_rsize_o  output  4, ram_rlen_o  output  8: shared memory read request.
REQ-009 SHALL have ports ram_rdata_ready_i  input  1, ram_rdata_i  input  DATA_W: memory beat strobe and data.
REQ-010 SHALL have ports grant_o  output  2 (bit0 icache, bit1 dcache, one-hot or zero) and busy_o  output  1.

Function
REQ-011 SHALL implement the FSM states IDLE, GNT_I and GNT_D; busy_o is 1 in GNT_I and GNT_D.
REQ-012 In IDLE with any valid request, SHALL register the grant at the clock edge; ram_raddr_valid_o asserts the next cycle (1-cycle arbitration latency).
REQ-013 In GNT_x, SHALL drive the ram_* request outputs combinationally from requester x; when not granted, ram_raddr_valid_o SHALL be 0 and the other request outputs 0.
REQ-014 SHALL drive x_rdata_ready_o = ram_rdata_ready_i & ram_raddr_valid_o for the granted requester only; the other requester's ready SHALL be 0.
REQ-015 SHALL broadcast ram_rdata_i unmodified on both i_rdata_o and d_rdata_o.
REQ-016 SHALL count beats with an 8-bit counter: cleared on grant, incremented on each handshake (ram_raddr_valid_o & ram_rdata_ready_i).
REQ-017 SHALL latch rlen at grant and compare against the latched value; a later change of x_rlen_i mid-burst SHALL be ignored.
REQ-018 On the handshake where count == latched rlen, SHALL return to IDLE next cycle; rlen=0 means a single beat, rlen=255 means 256 beats with no counter overflow effect.
REQ-019 SHALL NOT change the grant mid-burst, regardless of the other requester.
REQ-020 If the granted valid drops before the last beat, SHALL abort: next state IDLE, counter cleared, no ready issued in the drop cycle.
REQ-021 SHALL NOT re-arbitrate in the cycle of the last beat; re-arbitration occurs only in IDLE.

Reset
REQ-022 On rst, SHALL enter IDLE and clear the counter, latched rlen and round-robin pointer; all outputs SHALL read 0 the following cycle, including when rst is asserted mid-burst.

Configuration
REQ-023 With macro YSYX_041514_ARB_RR_EN defined, SHALL arbitrate simultaneous requests round-robin: the requester not granted last wins; the pointer resets to favour dcache.
REQ-024 Without YSYX_041514_ARB_RR_EN, SHALL use fixed priority: dcache always beats icache on simultaneous requests.

Verification
REQ-025 icache only, addr 0x8000_0040, rlen=7, ready every cycle -> grant_o=01 one cycle after valid, 8 i_rdata_ready_o pulses, then IDLE.
REQ-026 Both valid in the same cycle, default build -> dcache granted (grant_o=10); icache granted only after the dcache last beat plus one IDLE cycle.
REQ-027 RR build, both valid continuously, rlen=0 -> grant alternates 10,01,10,01.
REQ-028 dcache valid drops after 3 of 8 beats -> IDLE next cycle, no further d_rdata_ready_o, pending icache granted.
REQ-029 rst asserted during beat 4 of an icache burst -> next cycle grant_o=00, busy_o=0, ram_raddr_valid_o=0; a fresh burst after rst completes 8 beats.
REQ-030 rlen=255 with stalled ready (ready every 3rd cycle) -> exactly 256 handshakes, and the grant is held throughout.
